// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control unit: opcode values, FSM state
// encoding, execute-step constants, instruction classes and the strobe bundle.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        S_FETCH0,
        S_FETCH1,
        S_FETCH2,
        S_EXEC,
        S_HALT,
        S_STEPWAIT
    } state_t;

    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;
    localparam logic [2:0] T6 = 3'd6;
    localparam logic [2:0] T7 = 3'd7;

    typedef enum logic [4:0] {
        C_ALU,      // register-register ALU / shift
        C_IMM,      // addi/andi/ori
        C_LDI,
        C_LD,
        C_ST,
        C_MULDIV,
        C_UNARY,    // neg/not
        C_BR,
        C_JR,
        C_JAL,
        C_IN,
        C_OUT,
        C_MFHI,
        C_MFLO,
        C_NOP,
        C_HALT,
        C_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic pc_out, mdr_out, rzhi_out, rzlo_out, hi_out, lo_out, port_out, c_out, ba_out;
        logic pc_in, inc_pc, ir_in, mar_in, mdr_in, ry_in, rz_in, hi_in, lo_in;
        logic con_in, outport_in, link_in;
        logic rd, wr;
        logic gra, grb, grc, rin, rout;
        logic alu_add, run, instr_done, illegal_op;
    } ctrl_t;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode -> instruction class decoder.
// Ports: i_opcode (5-bit IR[31:27]) in, o_class (op_class_t) out.
module op_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] i_opcode,
    output op_class_t  o_class
);

    always_comb begin
        o_class = C_ILLEGAL;
        case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  o_class = C_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:         o_class = C_IMM;
            OP_LDI:                           o_class = C_LDI;
            OP_LD:                            o_class = C_LD;
            OP_ST:                            o_class = C_ST;
            OP_MUL, OP_DIV:                   o_class = C_MULDIV;
            OP_NEG, OP_NOT:                   o_class = C_UNARY;
            OP_BR:                            o_class = C_BR;
            OP_JR:                            o_class = C_JR;
            OP_JAL:                           o_class = C_JAL;
            OP_IN:                            o_class = C_IN;
            OP_OUT:                           o_class = C_OUT;
            OP_MFHI:                          o_class = C_MFHI;
            OP_MFLO:                          o_class = C_MFLO;
            OP_NOP:                           o_class = C_NOP;
            OP_HALT:                          o_class = C_HALT;
            default:                          o_class = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer for the single-bus 32-bit CPU datapath.
// Fetch (FETCH0..FETCH2) followed by per-opcode execute steps T3..T7.
// Ports:
//   clock, clear (sync active-high reset), ir[31:0] (opcode = ir[31:27]),
//   con_ff (branch condition), step (single-step advance)
//   bus drivers: PCout MDRout RZHIout RZLOout HIout LOout PORTout Cout BAout
//   loads: PCin IncPC IRin MARin MDRin RYin RZin HIin LOin CONin OUTPORTin link_in
//   memory: Read Write; select/encode: gra grb grc rin rout
//   status: alu_add run instr_done illegal_op
// Parameter MEM_WAIT (1..7): cycles a memory strobe is held.
// Optional feature macro SINGLE_STEP_EN: park in STEPWAIT after each
// instruction until a step pulse.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        step,
    output logic        PCout,
    output logic        MDRout,
    output logic        RZHIout,
    output logic        RZLOout,
    output logic        HIout,
    output logic        LOout,
    output logic        PORTout,
    output logic        Cout,
    output logic        BAout,
    output logic        PCin,
    output logic        IncPC,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        RYin,
    output logic        RZin,
    output logic        HIin,
    output logic        LOin,
    output logic        CONin,
    output logic        OUTPORTin,
    output logic        link_in,
    output logic        Read,
    output logic        Write,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        alu_add,
    output logic        run,
    output logic        instr_done,
    output logic        illegal_op
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    state_t     r_state, w_next_state;
    logic [2:0] r_step, w_next_step;
    logic [2:0] r_wait, w_next_wait;
    op_class_t  w_class;
    ctrl_t      w_c, w_out;
    logic       w_wait_last, w_advance, w_done;

`ifdef SINGLE_STEP_EN
    logic w_unused;
    assign w_unused = ^ir[26:0];
`else
    logic w_unused;
    assign w_unused = ^{ir[26:0], step};
`endif

    op_class_decode u_dec (
        .i_opcode (ir[31:27]),
        .o_class  (w_class)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_FETCH0;
            r_step  <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next_state;
            r_step  <= w_next_step;
            r_wait  <= w_next_wait;
        end
    end

    assign w_wait_last = (r_wait == WAIT_LAST);

    always_comb begin
        w_c          = '0;
        w_next_state = r_state;
        w_next_step  = r_step;
        w_next_wait  = '0;     // any cycle that is not a held memory cycle restarts the wait
        w_advance    = 1'b1;
        w_done       = 1'b0;

        case (r_state)
            S_FETCH0: begin
                w_c.pc_out = 1'b1; w_c.mar_in = 1'b1; w_c.inc_pc = 1'b1;
                w_next_state = S_FETCH1;
            end
            S_FETCH1: begin
                w_c.rd = 1'b1;
                if (w_wait_last) begin
                    w_c.mdr_in   = 1'b1;
                    w_next_state = S_FETCH2;
                end else begin
                    w_next_wait = r_wait + 3'd1;
                end
            end
            S_FETCH2: begin
                w_c.mdr_out = 1'b1; w_c.ir_in = 1'b1;
                w_next_state = S_EXEC;
                w_next_step  = T3;
            end
            S_EXEC: begin
                case (w_class)
                    C_ALU, C_IMM: begin
                        case (r_step)
                            T3: begin w_c.grb = 1'b1; w_c.rout = 1'b1; w_c.ry_in = 1'b1; end
                            T4: begin
                                if (w_class == C_ALU) begin
                                    w_c.grc = 1'b1; w_c.rout = 1'b1;
                                end else begin
                                    w_c.c_out = 1'b1;
                                end
                                w_c.rz_in = 1'b1;
                            end
                            T5: begin w_c.rzlo_out = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1; w_done = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_LDI, C_LD, C_ST: begin
                        case (r_step)
                            T3: begin w_c.grb = 1'b1; w_c.ba_out = 1'b1; w_c.ry_in = 1'b1; end
                            T4: begin w_c.c_out = 1'b1; w_c.rz_in = 1'b1; w_c.alu_add = 1'b1; end
                            T5: begin
                                w_c.rzlo_out = 1'b1;
                                if (w_class == C_LDI) begin
                                    w_c.gra = 1'b1; w_c.rin = 1'b1; w_done = 1'b1;
                                end else begin
                                    w_c.mar_in = 1'b1;
                                end
                            end
                            T6: begin
                                if (w_class == C_LD) begin
                                    // Read held for MEM_WAIT cycles, step frozen until the last
                                    w_c.rd = 1'b1;
                                    if (w_wait_last) w_c.mdr_in = 1'b1;
                                    else begin w_advance = 1'b0; w_next_wait = r_wait + 3'd1; end
                                end else begin
                                    w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.mdr_in = 1'b1;
                                end
                            end
                            T7: begin
                                if (w_class == C_LD) begin
                                    w_c.mdr_out = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1; w_done = 1'b1;
                                end else begin
                                    w_c.wr = 1'b1;
                                    if (w_wait_last) w_done = 1'b1;
                                    else begin w_advance = 1'b0; w_next_wait = r_wait + 3'd1; end
                                end
                            end
                            default: ;
                        endcase
                    end
                    C_MULDIV: begin
                        case (r_step)
                            T3: begin w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.ry_in = 1'b1; end
                            T4: begin w_c.grb = 1'b1; w_c.rout = 1'b1; w_c.rz_in = 1'b1; end
                            T5: begin w_c.rzlo_out = 1'b1; w_c.lo_in = 1'b1; end
                            T6: begin w_c.rzhi_out = 1'b1; w_c.hi_in = 1'b1; w_done = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_UNARY: begin
                        case (r_step)
                            T3: begin w_c.grb = 1'b1; w_c.rout = 1'b1; w_c.rz_in = 1'b1; end
                            T4: begin w_c.rzlo_out = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1; w_done = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_BR: begin
                        case (r_step)
                            T3: begin w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.con_in = 1'b1; end
                            T4: begin w_c.pc_out = 1'b1; w_c.ry_in = 1'b1; end
                            T5: begin w_c.c_out = 1'b1; w_c.rz_in = 1'b1; w_c.alu_add = 1'b1; end
                            T6: begin
                                // branch not taken: an idle step that still completes
                                if (con_ff) begin w_c.rzlo_out = 1'b1; w_c.pc_in = 1'b1; end
                                w_done = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    C_JAL: begin
                        case (r_step)
                            T3: begin w_c.pc_out = 1'b1; w_c.link_in = 1'b1; end
                            T4: begin w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.pc_in = 1'b1; w_done = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_JR:   begin w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.pc_in = 1'b1; w_done = 1'b1; end
                    C_IN:   begin w_c.port_out = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1; w_done = 1'b1; end
                    C_OUT:  begin w_c.gra = 1'b1; w_c.rout = 1'b1; w_c.outport_in = 1'b1; w_done = 1'b1; end
                    C_MFHI: begin w_c.hi_out = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1; w_done = 1'b1; end
                    C_MFLO: begin w_c.lo_out = 1'b1; w_c.gra = 1'b1; w_c.rin = 1'b1; w_done = 1'b1; end
                    C_NOP:  w_done = 1'b1;
                    C_HALT: begin w_next_state = S_HALT; w_advance = 1'b0; end
                    default: begin w_c.illegal_op = 1'b1; w_done = 1'b1; end
                endcase
            end
`ifdef SINGLE_STEP_EN
            S_STEPWAIT: begin
                if (step) w_next_state = S_FETCH0;
            end
`endif
            default: ;   // S_HALT: everything off until clear
        endcase

        if (w_done) begin
            w_c.instr_done = 1'b1;
            w_next_step    = '0;
`ifdef SINGLE_STEP_EN
            w_next_state   = S_STEPWAIT;
`else
            w_next_state   = S_FETCH0;
`endif
        end else if (r_state == S_EXEC && w_advance) begin
            w_next_step = r_step + 3'd1;
        end

        w_c.run = (r_state != S_HALT);
    end

    // clear silences every strobe in the same cycle so an in-flight Write is cut off
    assign w_out = clear ? '0 : w_c;

    assign PCout      = w_out.pc_out;
    assign MDRout     = w_out.mdr_out;
    assign RZHIout    = w_out.rzhi_out;
    assign RZLOout    = w_out.rzlo_out;
    assign HIout      = w_out.hi_out;
    assign LOout      = w_out.lo_out;
    assign PORTout    = w_out.port_out;
    assign Cout       = w_out.c_out;
    assign BAout      = w_out.ba_out;
    assign PCin       = w_out.pc_in;
    assign IncPC      = w_out.inc_pc;
    assign IRin       = w_out.ir_in;
    assign MARin      = w_out.mar_in;
    assign MDRin      = w_out.mdr_in;
    assign RYin       = w_out.ry_in;
    assign RZin       = w_out.rz_in;
    assign HIin       = w_out.hi_in;
    assign LOin       = w_out.lo_in;
    assign CONin      = w_out.con_in;
    assign OUTPORTin  = w_out.outport_in;
    assign link_in    = w_out.link_in;
    assign Read       = w_out.rd;
    assign Write      = w_out.wr;
    assign gra        = w_out.gra;
    assign grb        = w_out.grb;
    assign grc        = w_out.grc;
    assign rin        = w_out.rin;
    assign rout       = w_out.rout;
    assign alu_add    = w_out.alu_add;
    assign run        = w_out.run;
    assign instr_done = w_out.instr_done;
    assign illegal_op = w_out.illegal_op;

    // single bus: never more than one driver per cycle
    a_bus_onehot: assert property (@(posedge clock)
        $onehot0({PCout, MDRout, RZHIout, RZLOout, HIout, LOout, PORTout, Cout, BAout}));

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level model expands each opcode's
// step list (with memory waits) into an expected per-cycle strobe vector.
module tb_control_unit;

    localparam int MW = 3;

    logic clock = 1'b0, clear = 1'b1, con_ff = 1'b0, step = 1'b0;
    logic [31:0] ir = '0;
    logic PCout, MDRout, RZHIout, RZLOout, HIout, LOout, PORTout, Cout, BAout;
    logic PCin, IncPC, IRin, MARin, MDRin, RYin, RZin, HIin, LOin, CONin, OUTPORTin, link_in;
    logic Read, Write, gra, grb, grc, rin, rout, alu_add, run, instr_done, illegal_op;

    always #5 clock = ~clock;

    control_unit #(.MEM_WAIT(MW)) dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .step(step),
        .PCout(PCout), .MDRout(MDRout), .RZHIout(RZHIout), .RZLOout(RZLOout),
        .HIout(HIout), .LOout(LOout), .PORTout(PORTout), .Cout(Cout), .BAout(BAout),
        .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .RYin(RYin), .RZin(RZin), .HIin(HIin), .LOin(LOin), .CONin(CONin),
        .OUTPORTin(OUTPORTin), .link_in(link_in), .Read(Read), .Write(Write),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .alu_add(alu_add),
        .run(run), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    logic [31:0] obs;
    assign obs = {PCout, MDRout, RZHIout, RZLOout, HIout, LOout, PORTout, Cout, BAout,
                  PCin, IncPC, IRin, MARin, MDRin, RYin, RZin, HIin, LOin, CONin,
                  OUTPORTin, link_in, Read, Write, gra, grb, grc, rin, rout,
                  alu_add, run, instr_done, illegal_op};

    localparam logic [31:0] K_PCOUT = 32'h1 << 31, K_MDROUT = 32'h1 << 30, K_RZHI = 32'h1 << 29;
    localparam logic [31:0] K_RZLO  = 32'h1 << 28, K_HIOUT  = 32'h1 << 27, K_LOOUT = 32'h1 << 26;
    localparam logic [31:0] K_PORT  = 32'h1 << 25, K_COUT   = 32'h1 << 24, K_BAOUT = 32'h1 << 23;
    localparam logic [31:0] K_PCIN  = 32'h1 << 22, K_INCPC  = 32'h1 << 21, K_IRIN  = 32'h1 << 20;
    localparam logic [31:0] K_MARIN = 32'h1 << 19, K_MDRIN  = 32'h1 << 18, K_RYIN  = 32'h1 << 17;
    localparam logic [31:0] K_RZIN  = 32'h1 << 16, K_HIIN   = 32'h1 << 15, K_LOIN  = 32'h1 << 14;
    localparam logic [31:0] K_CONIN = 32'h1 << 13, K_OPIN   = 32'h1 << 12, K_LINK  = 32'h1 << 11;
    localparam logic [31:0] K_READ  = 32'h1 << 10, K_WRITE  = 32'h1 << 9,  K_GRA   = 32'h1 << 8;
    localparam logic [31:0] K_GRB   = 32'h1 << 7,  K_GRC    = 32'h1 << 6,  K_RIN   = 32'h1 << 5;
    localparam logic [31:0] K_ROUT  = 32'h1 << 4,  K_ADD    = 32'h1 << 3,  K_RUN   = 32'h1 << 2;
    localparam logic [31:0] K_DONE  = 32'h1 << 1,  K_ILL    = 32'h1;

    int n_cmp = 0, n_err = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %08h want %08h", tag, got, want);
        end
    endtask

    task automatic push(input logic [31:0] m);
        exp_q.push_back(m | K_RUN);
    endtask

    // a memory step: strobe held MW cycles, extra strobe only on the final one
    task automatic push_mem(input logic [31:0] m, input logic [31:0] last_extra);
        for (int k = 0; k < MW; k++) push(m | ((k == MW - 1) ? last_extra : 32'h0));
    endtask

    task automatic build(input logic [4:0] op, input logic con);
        exp_q.delete();
        push(K_PCOUT | K_MARIN | K_INCPC);
        push_mem(K_READ, K_MDRIN);
        push(K_MDROUT | K_IRIN);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
                push(K_GRB | K_ROUT | K_RYIN); push(K_GRC | K_ROUT | K_RZIN); push(K_RZLO | K_GRA | K_RIN);
            end
            5'd12, 5'd13, 5'd14: begin
                push(K_GRB | K_ROUT | K_RYIN); push(K_COUT | K_RZIN); push(K_RZLO | K_GRA | K_RIN);
            end
            5'd1: begin
                push(K_GRB | K_BAOUT | K_RYIN); push(K_COUT | K_RZIN | K_ADD); push(K_RZLO | K_GRA | K_RIN);
            end
            5'd0: begin
                push(K_GRB | K_BAOUT | K_RYIN); push(K_COUT | K_RZIN | K_ADD); push(K_RZLO | K_MARIN);
                push_mem(K_READ, K_MDRIN); push(K_MDROUT | K_GRA | K_RIN);
            end
            5'd2: begin
                push(K_GRB | K_BAOUT | K_RYIN); push(K_COUT | K_RZIN | K_ADD); push(K_RZLO | K_MARIN);
                push(K_GRA | K_ROUT | K_MDRIN); push_mem(K_WRITE, 32'h0);
            end
            5'd15, 5'd16: begin
                push(K_GRA | K_ROUT | K_RYIN); push(K_GRB | K_ROUT | K_RZIN);
                push(K_RZLO | K_LOIN); push(K_RZHI | K_HIIN);
            end
            5'd17, 5'd18: begin push(K_GRB | K_ROUT | K_RZIN); push(K_RZLO | K_GRA | K_RIN); end
            5'd19: begin
                push(K_GRA | K_ROUT | K_CONIN); push(K_PCOUT | K_RYIN); push(K_COUT | K_RZIN | K_ADD);
                push(con ? (K_RZLO | K_PCIN) : 32'h0);
            end
            5'd20: push(K_GRA | K_ROUT | K_PCIN);
            5'd21: begin push(K_PCOUT | K_LINK); push(K_GRA | K_ROUT | K_PCIN); end
            5'd22: push(K_PORT | K_GRA | K_RIN);
            5'd23: push(K_GRA | K_ROUT | K_OPIN);
            5'd24: push(K_LOOUT | K_GRA | K_RIN);
            5'd25: push(K_HIOUT | K_GRA | K_RIN);
            5'd26, 5'd27: push(32'h0);
            default: push(K_ILL);
        endcase
        if (op != 5'd27) exp_q[exp_q.size() - 1] = exp_q[exp_q.size() - 1] | K_DONE;
    endtask

    task automatic do_reset();
        clear = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("reset", obs, 32'h0);
            @(posedge clock); #1;
        end
        clear = 1'b0;
    endtask

    // runs one instruction from FETCH0; abort_at >= 0 asserts clear in that cycle
    task automatic run_instr(input logic [31:0] irv, input logic con, input int abort_at);
        int n;
        ir = irv;
        con_ff = con;
        build(irv[31:27], con);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
`ifdef SINGLE_STEP_EN
            step = (i == n - 1);   // must be ignored in the done cycle
`else
            step = 1'($urandom);
`endif
            @(negedge clock);
            chk($sformatf("op%0d c%0d", irv[31:27], i), obs, exp_q[i]);
            if (i == abort_at) begin
                clear = 1'b1;
                #1 chk("abort_now", obs, 32'h0);
                @(posedge clock); #1;
                @(negedge clock);
                chk("abort_hold", obs, 32'h0);
                @(posedge clock); #1;
                clear = 1'b0;
                return;
            end
            @(posedge clock); #1;
        end
`ifdef SINGLE_STEP_EN
        if (irv[31:27] != 5'd27) begin
            step = 1'b0;
            repeat ($urandom_range(1, 4)) begin
                @(negedge clock);
                chk("stepwait", obs, K_RUN);
                @(posedge clock); #1;
            end
            step = 1'b1;
            @(negedge clock);
            chk("step_pulse", obs, K_RUN);
            @(posedge clock); #1;
            step = 1'b0;
        end
`endif
    endtask

    initial begin
        logic [4:0] op;
        do_reset();
        run_instr(32'h18918000, 1'b0, -1);                   // add
        run_instr({5'd0, 27'($urandom)}, 1'b0, -1);          // ld
        run_instr({5'd19, 27'($urandom)}, 1'b0, -1);         // br not taken
        run_instr({5'd19, 27'($urandom)}, 1'b1, -1);         // br taken
        run_instr({5'd30, 27'($urandom)}, 1'b0, -1);         // illegal
        run_instr({5'd2, 27'($urandom)}, 1'b0, -1);          // st complete
        run_instr({5'd2, 27'($urandom)}, 1'b0, 5 + 7 - 2);   // st aborted mid-Write
        for (int j = 0; j < 40; j++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            run_instr({op, 27'($urandom)}, 1'($urandom), -1);
        end
        run_instr({5'd27, 27'($urandom)}, 1'b0, -1);         // halt
        repeat (20) begin
            step = 1'($urandom);
            @(negedge clock);
            chk("halted", obs, 32'h0);
            @(posedge clock); #1;
        end
        step = 1'b0;
        do_reset();
        run_instr({5'd26, 27'($urandom)}, 1'b0, -1);
        run_instr({5'd16, 27'($urandom)}, 1'b0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
